// File: rtl/dir_input_encoder.sv
// dir_input_encoder
//   Turns four asynchronous push buttons into a committed one-hot snake
//   direction. Buttons are synchronised and debounced, and each debounced press
//   is filtered against the direction the snake will have by then. Turns wait
//   in a small queue until the next rising edge of move_clk commits one.
//
// Configuration:
//   DIR_QUEUE2_EN  defined   -> two-entry turn FIFO
//                  undefined -> single-entry turn buffer (default)
//
// Parameters:
//   DEBOUNCE_CNT  number of consecutive sample_tick strobes (1..255) that a
//                 level must hold before it is accepted
//
// Ports:
//   vga_clk      system clock
//   reset        synchronous active-high reset
//   btn_raw[3:0] asynchronous buttons, [3]=up [2]=down [1]=left [0]=right
//   sample_tick  one-cycle debounce sample strobe
//   move_clk     asynchronous snake update clock; its rising edge commits
//   game_over    freezes direction input and flushes the queue
//   dir[3:0]     committed one-hot direction (same bit map as btn_raw)
//   pending      high while at least one turn is queued
module dir_input_encoder #(
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       sample_tick,
    input  logic       move_clk,
    input  logic       game_over,
    output logic [3:0] dir,
    output logic       pending
);

    // The reverse of a one-hot direction: swap up/down and left/right.
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // A turn is legal unless it repeats or reverses the reference direction.
    function automatic logic turn_ok(input logic [3:0] turn, input logic [3:0] ref_dir);
        return (turn != ref_dir) && (turn != opposite(ref_dir));
    endfunction

    // ---- synchronisers ----
    logic [3:0] btn_s1, btn_s2;
    logic       mv_s1, mv_s2, mv_s3;
    logic       commit;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            mv_s1  <= 1'b0;
            mv_s2  <= 1'b0;
            mv_s3  <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            mv_s1  <= move_clk;
            mv_s2  <= mv_s1;
            mv_s3  <= mv_s2;
        end
    end

    // The third move_clk flop only serves as the previous value for edge detect.
    assign commit = mv_s2 & ~mv_s3;

    // ---- debounce ----
    logic [7:0] db_cnt [4];
    logic [3:0] stable;
    logic [3:0] press_evt;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            stable    <= '0;
            press_evt <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_evt[i] <= 1'b0;
                if (btn_s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (sample_tick) begin
                    // This tick is the DEBOUNCE_CNT-th consecutive differing one.
                    if (db_cnt[i] == 8'(DEBOUNCE_CNT - 1)) begin
                        stable[i]    <= ~stable[i];
                        db_cnt[i]    <= '0;
                        press_evt[i] <= ~stable[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ---- priority pick: up > down > left > right ----
    logic [3:0] pick;

    always_comb begin
        pick = 4'b0000;
        if (press_evt[3])      pick = 4'b1000;
        else if (press_evt[2]) pick = 4'b0100;
        else if (press_evt[1]) pick = 4'b0010;
        else if (press_evt[0]) pick = 4'b0001;
    end

    // ---- turn queue and committed direction ----
    logic [3:0] dir_n;
    logic [3:0] q0, q0_n;

`ifdef DIR_QUEUE2_EN
    logic [3:0] q1, q1_n;
    logic [1:0] q_cnt, q_cnt_n;

    // Commit first, then judge the press against what remains; with the FIFO
    // full, the press replaces the newest entry and is judged against q0.
    always_comb begin
        dir_n   = dir;
        q0_n    = q0;
        q1_n    = q1;
        q_cnt_n = q_cnt;
        if (game_over) begin
            q_cnt_n = 2'd0;
        end else begin
            if (commit && (q_cnt != 2'd0)) begin
                dir_n   = q0;
                q0_n    = q1;
                q_cnt_n = q_cnt - 2'd1;
            end
            if (pick != 4'b0000) begin
                case (q_cnt_n)
                    2'd0: begin
                        if (turn_ok(pick, dir_n)) begin
                            q0_n    = pick;
                            q_cnt_n = 2'd1;
                        end
                    end
                    2'd1: begin
                        if (turn_ok(pick, q0_n)) begin
                            q1_n    = pick;
                            q_cnt_n = 2'd2;
                        end
                    end
                    default: begin
                        if (turn_ok(pick, q0_n)) q1_n = pick;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dir     <= 4'b0001;
            q0      <= 4'b0001;
            q1      <= 4'b0001;
            q_cnt   <= 2'd0;
            pending <= 1'b0;
        end else begin
            dir     <= dir_n;
            q0      <= q0_n;
            q1      <= q1_n;
            q_cnt   <= q_cnt_n;
            pending <= (q_cnt_n != 2'd0);
        end
    end
`else
    logic q_vld, q_vld_n;

    // With a single slot, both the empty and the overwrite cases judge the
    // press against the direction that will be current after any commit.
    always_comb begin
        dir_n   = dir;
        q0_n    = q0;
        q_vld_n = q_vld;
        if (game_over) begin
            q_vld_n = 1'b0;
        end else begin
            if (commit && q_vld) begin
                dir_n   = q0;
                q_vld_n = 1'b0;
            end
            if ((pick != 4'b0000) && turn_ok(pick, dir_n)) begin
                q0_n    = pick;
                q_vld_n = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dir     <= 4'b0001;
            q0      <= 4'b0001;
            q_vld   <= 1'b0;
            pending <= 1'b0;
        end else begin
            dir     <= dir_n;
            q0      <= q0_n;
            q_vld   <= q_vld_n;
            pending <= q_vld_n;
        end
    end
`endif

endmodule

// File: tb/tb_dir_input_encoder.sv
module tb_dir_input_encoder;

    localparam int DB = 20;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       sample_tick;
    logic       move_clk = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] dir;
    logic       pending;
    logic [1:0] tick_div = 2'd0;

    int checks = 0;
    int failures = 0;

    dir_input_encoder #(.DEBOUNCE_CNT(DB)) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sample_tick(sample_tick),
        .move_clk   (move_clk),
        .game_over  (game_over),
        .dir        (dir),
        .pending    (pending)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) tick_div <= tick_div + 2'd1;
    assign sample_tick = (tick_div == 2'd3);

    typedef struct {
        logic       do_reset;
        logic [3:0] btn;
        logic       exp_pending;
        logic [3:0] exp_dir;
    } vec_t;

    vec_t vecs [9];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic ticks(input int n);
        cycles(n * 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(4);
        reset = 1'b0;
        cycles(2);
    endtask

    // Hold a button pattern long enough to debounce, then release it fully.
    task automatic press(input logic [3:0] mask);
        btn_raw = mask;
        ticks(DB + 5);
        btn_raw = 4'b0000;
        ticks(DB + 5);
    endtask

    task automatic move_edge();
        move_clk = 1'b1;
        cycles(8);
        move_clk = 1'b0;
        cycles(8);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0001};
        vecs[1] = '{1'b0, 4'b0010, 1'b0, 4'b0001}; // left vs right: reversal
        vecs[2] = '{1'b0, 4'b1000, 1'b1, 4'b1000}; // up accepted
        vecs[3] = '{1'b0, 4'b0100, 1'b0, 4'b1000}; // down vs up: reversal
        vecs[4] = '{1'b0, 4'b0010, 1'b1, 4'b0010}; // left accepted
        vecs[5] = '{1'b0, 4'b1001, 1'b1, 4'b1000}; // up beats right
        vecs[6] = '{1'b0, 4'b0001, 1'b1, 4'b0001}; // right accepted
        vecs[7] = '{1'b0, 4'b1111, 1'b1, 4'b1000}; // up beats all
        vecs[8] = '{1'b0, 4'b0110, 1'b0, 4'b1000}; // down wins, is reversal, left dropped

        do_reset();
        check4("reset_dir", dir, 4'b0001);
        check1("reset_pending", pending, 1'b0);

        // Idle move_clk edges leave the default direction.
        for (int i = 0; i < 5; i++) begin
            move_edge();
            check4("idle_dir", dir, 4'b0001);
            check1("idle_pending", pending, 1'b0);
        end

        // Table-driven single-press vectors.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_reset) do_reset();
            press(vecs[i].btn);
            check1($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pending);
            move_edge();
            check4($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
            check1($sformatf("vec%0d_pending_after", i), pending, 1'b0);
        end

        // Bouncing up button, then a clean hold.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            ticks(5);
            check1("bounce_no_press", pending, 1'b0);
        end
        btn_raw = 4'b1000;
        ticks(DB - 2);
        check1("bounce_early", pending, 1'b0);
        ticks(6);
        check1("bounce_accepted", pending, 1'b1);
        btn_raw = 4'b0000;
        ticks(DB + 5);
        move_edge();
        check4("bounce_dir", dir, 4'b1000);
        check1("bounce_pending_after", pending, 1'b0);

        // Two quick turns before a commit: up then left.
        do_reset();
        press(4'b1000);
        press(4'b0010);
        check1("two_turn_pending", pending, 1'b1);
        move_edge();
        check4("two_turn_dir1", dir, 4'b1000);
`ifdef DIR_QUEUE2_EN
        check1("two_turn_pending1", pending, 1'b1);
        move_edge();
        check4("two_turn_dir2", dir, 4'b0010);
`else
        check1("two_turn_pending1", pending, 1'b0);
        move_edge();
        check4("two_turn_dir2", dir, 4'b1000);
`endif

        // Up then down before a commit: single slot compares down against dir.
        do_reset();
        press(4'b1000);
        press(4'b0100);
        move_edge();
`ifdef DIR_QUEUE2_EN
        check4("overwrite_dir", dir, 4'b1000);
`else
        check4("overwrite_dir", dir, 4'b0100);
`endif

        // game_over flushes the queue and freezes direction.
        do_reset();
        press(4'b1000);
        check1("go_queued", pending, 1'b1);
        game_over = 1'b1;
        cycles(3);
        check1("go_flush", pending, 1'b0);
        press(4'b0010);
        move_edge();
        move_edge();
        check4("go_dir", dir, 4'b0001);
        check1("go_pending", pending, 1'b0);
        game_over = 1'b0;
        move_edge();
        check4("go_release_dir", dir, 4'b0001);
        do_reset();
        check4("go_reset_dir", dir, 4'b0001);

        // Reset in the middle of a debounce leaves no event behind.
        btn_raw = 4'b1000;
        ticks(10);
        reset = 1'b1;
        btn_raw = 4'b0000;
        cycles(4);
        reset = 1'b0;
        ticks(DB + 10);
        check1("mid_db_pending", pending, 1'b0);
        move_edge();
        check4("mid_db_dir", dir, 4'b0001);

        // Button held through reset release yields exactly one press.
        btn_raw = 4'b1000;
        do_reset();
        ticks(DB - 2);
        check1("held_early", pending, 1'b0);
        ticks(6);
        check1("held_press", pending, 1'b1);
        btn_raw = 4'b0000;
        ticks(DB + 5);
        move_edge();
        check4("held_dir", dir, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dir_input_encoder.md
DIR_INPUT_ENCODER -- requirements
Module: dir_input_encoder

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 20, number of consecutive sample_tick strobes a synchronised button level must hold before it is accepted (range 1..255).
REQ-002 Port vga_clk  input  1  system clock; reset is synchronous, active-high, on clock vga_clk.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port btn_raw  input  4  asynchronous active-high buttons; [3]=up, [2]=down, [1]=left, [0]=right.
REQ-005 Port sample_tick  input  1  one-vga_clk-wide debounce sample strobe, nominally 1 kHz.
REQ-006 Port move_clk  input  1  asynchronous snake update clock, nominally 2 Hz; committed on its rising edge.
REQ-007 Port game_over  input  1  high freezes direction input.
REQ-008 Port dir  output  4  committed one-hot direction, same bit map as btn_raw, to the game controller.
REQ-009 Port pending  output  1  high while at least one turn is queued.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchroniser; move_clk SHALL pass through a 3-flop synchroniser, and its rising edge SHALL be detected as a single-cycle commit strobe.
REQ-011 Per button, an 8-bit counter SHALL increment on sample_tick while the synchronised level differs from the stable level, clear when they match, and the stable level SHALL toggle and the counter clear when the count reaches DEBOUNCE_CNT.
REQ-012 A press event SHALL be a 0->1 transition of a stable level, one cycle wide.
REQ-013 Simultaneous press events SHALL resolve by fixed priority up > down > left > right; the lower-priority events in that cycle are discarded.
REQ-014 Reference direction = newest queued entry if any, else dir.
REQ-015 A press equal to or opposite (up/down, left/right) the reference direction SHALL be discarded; otherwise it SHALL be written to the queue.
REQ-016 On a commit strobe with the queue non-empty, dir SHALL load the oldest entry on the next edge and that entry SHALL be removed; with the queue empty, dir holds.
REQ-017 Press and commit in the same cycle: the commit SHALL take effect, and the press SHALL be checked against the value being committed (or the remaining entry, if any).
REQ-018 When the queue is full, a new accepted press SHALL overwrite the newest entry, with the reversal check made against the entry preceding it (or dir).
REQ-019 While game_over is high, press events SHALL be discarded, the queue SHALL clear, and commits SHALL not change dir.
REQ-020 dir SHALL always be exactly one-hot; pending = queue non-empty, registered.

Reset
REQ-021 On reset: dir = 4'b0001 (right), queue empty, pending = 0, debounce counters = 0, stable levels = 0, all synchroniser flops = 0.
REQ-022 Reset asserted mid-debounce or mid-commit SHALL abort the operation with no residual event after release.
REQ-023 A button held through reset release SHALL produce one press event after DEBOUNCE_CNT samples.

Configuration
REQ-024 Macro DIR_QUEUE2_EN defined: queue depth 2 (FIFO), so two quick turns (e.g. up then left) commit on two successive move_clk edges.
REQ-025 DIR_QUEUE2_EN undefined: queue depth 1, and REQ-018 applies to the single entry, with the check made against dir.

Verification
REQ-026 Reset, then no input for 5 move_clk edges -> dir = 4'b0001 throughout, pending = 0.
REQ-027 DEBOUNCE_CNT=20: btn_raw[3] toggles 0/1 every 5 sample_ticks for 200 ticks, then held 1 -> exactly one press after 20 stable ticks; dir = 4'b1000 after the next move_clk edge.
REQ-028 With dir = right, press left -> discarded, pending stays 0; dir = 4'b0001 after the next move_clk edge.
REQ-029 Press up and right in the same cycle with dir = left -> up queued; dir = 4'b1000 after the commit.
REQ-030 DIR_QUEUE2_EN defined, dir = right: press up, then left before move_clk -> dir = 4'b1000 after the 1st edge, 4'b0010 after the 2nd; with the macro undefined -> left is discarded as opposite of right, dir = 4'b1000 after the 1st edge.
REQ-031 Queue holds up, game_over is raised, then move_clk edges occur -> pending = 0 and dir is unchanged; after reset, dir = 4'b0001.
